dualportram_port_arbiter: RTL and testbench
===========================================

Name: dualportram_port_arbiter

Overview:
- Shares port A of a dualportram instance among NREQ requesters.
- Per-cycle round-robin arbitration: valid/ready request handshake in, registered RAM command out, read data routed back to the owning requester.
- Reads and writes with address at or above the RAM-reported length are rejected: no RAM access, sticky error flag.
- Port B stays directly owned by its single user and is outside this block.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, RAM data width; must match the RAM instance

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  request valid, one bit per requester
- req_we  in  NREQ  1 = write, 0 = read
- req_address  in  NREQ*32  flattened; requester i uses bits [32*i+31:32*i]
- req_din  in  NREQ*WIDTH  flattened write data
- gnt  out  NREQ  ready; combinational; request i is accepted at the edge where req[i] and gnt[i] are both 1
- rvalid  out  NREQ  read response strobe for requester i
- rdata  out  WIDTH  read data, shared by all requesters; qualified by rvalid
- oob_err  out  1  sticky out-of-range error flag
- ram_we  out  1  drives the RAM we input
- ram_oe  out  1  drives the RAM oe input
- ram_address  out  32  drives the RAM address input
- ram_din  out  WIDTH  drives the RAM din input
- ram_dout  in  WIDTH  from the RAM dout output (registered inside the RAM)
- ram_length  in  32  from the RAM length output

Behaviour:
- Reset (synchronous, active-high): ram_we=0, ram_oe=0, ram_address=0, ram_din=0, rvalid=0, oob_err=0, read pipeline cleared, round-robin pointer=0.
- After reset, requester 0 has highest priority.
- gnt is one-hot or zero. It depends only on req and the pointer, never on req_we or req_address.
- Arbitration is a rotating scan starting at the pointer. gnt is 0 for every requester with req=0.
- gnt is forced to 0 while reset=1.
- On acceptance of requester k, the pointer becomes (k+1) mod NREQ. With no acceptance, the pointer holds.
- Requesters keep req and payload stable until accepted. Deasserting req before acceptance is legal: the request is withdrawn.
- One transaction is accepted per cycle, giving throughput 1 with no bubbles.
- Cycle 0, edge E0: handshake. The arbiter registers the RAM command.
- Cycle 1: in range (address < ram_length):
  - write: ram_we=1, ram_oe=0
  - read: ram_oe=1, ram_we=0
  - ram_address and ram_din carry the payload.
- Cycle 1: out of range: ram_we=0 and ram_oe=0; oob_err set to 1 and held until reset.
- Cycle 1: no accepted transaction: ram_we=0 and ram_oe=0; address and data hold their previous values.
- Read owner index and OOB bit travel through a 2-stage pipeline.
- Cycle 2: rvalid[k]=1 for exactly one cycle.
  - In range: rdata = ram_dout.
  - Out of range: rdata = 0.
  - rdata is a don't-care when no rvalid bit is set.
- Read latency is 2 cycles from the handshake edge to rvalid. Writes return no response.
- Comparison against ram_length is unsigned and sampled in the handshake cycle. Address ram_length-1 is legal; address ram_length is OOB.
- Write then read of the same address in consecutive accepts returns the new data. The write reaches the RAM one cycle before the read.
- Reset asserted with reads in flight: pipeline cleared, and no rvalid appears for those reads.
- A request presented during reset is not accepted.

Decomposition:
- Package dualportram_arb_pkg: READ_LATENCY=2 constant; index width function clog2(NREQ).
- Sub-module rr_arbiter (parameter NREQ): inputs req and advance, output one-hot gnt, owns the pointer.
- Datapath muxing and the response pipeline stay in the top module.

Test Plan:
- Single read: RAM preloaded with mem[5]=0xDEADBEEF; req[2]=1 reading address 5 -> gnt[2] in the same cycle, ram_oe=1 with ram_address=5 next cycle, rvalid[2]=1 with rdata=0xDEADBEEF two cycles after the handshake.
- Fairness: req=4'b1111 held for 8 cycles, writes only -> acceptance order 0,1,2,3,0,1,2,3, one per cycle, ram_we=1 on 8 consecutive cycles.
- Pointer rotation: req=4'b1001 after requester 0 is accepted -> requester 3 accepted next, then requester 0.
- Out of range: ram_length=1024; read of address 1024 by requester 1 -> ram_oe=0, rvalid[1] at +2 with rdata=0, oob_err=1 and held. A later read of address 1023 -> normal RAM access.
- Write-then-read: requester 0 writes 0x12345678 to address 7, then reads address 7 on the next accept -> rdata=0x12345678.
- Reset mid-flight: two reads accepted, reset pulsed the following cycle -> no rvalid, all outputs at reset values, requester 0 wins the first post-reset arbitration.

Source files
------------

// File: rtl/dualportram_arb_pkg.sv
// Shared constants and helpers for the dualportram port-A arbiter.
//   READ_LATENCY : edges from the request handshake to the rvalid strobe
//   clog2()      : index width for a requester count
package dualportram_arb_pkg;

  localparam int READ_LATENCY = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   i_req      : request vector, one bit per requester
//   i_advance  : a grant was taken this cycle; move the pointer past the winner
//   o_gnt      : one-hot (or zero) grant, forced to zero while reset is high
module rr_arbiter
  import dualportram_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_gnt
);

  localparam int PW = clog2(NREQ);

  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_ptr_next;
  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_masked;
  logic [NREQ-1:0] w_pick;
  logic [NREQ-1:0] w_gnt;

  // Requesters at or above the pointer are scanned first; if none of them
  // asks, the scan wraps to the lowest requesting index.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_mask[i] = (PW'(i) >= r_ptr);
    end
  end

  assign w_masked = i_req & w_mask;
  assign w_pick   = (|w_masked) ? w_masked : i_req;
  // Isolate the lowest set bit of the chosen vector.
  assign w_gnt    = w_pick & (~w_pick + NREQ'(1));
  assign o_gnt    = reset ? '0 : w_gnt;

  always_comb begin
    w_ptr_next = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_ptr_next = (i == NREQ - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/dualportram_port_arbiter.sv
// Shares port A of a dualportram among NREQ requesters.
//   clk, reset     : clock, synchronous active-high reset
//   req/req_we     : per-requester valid and write flag
//   req_address    : flattened 32-bit addresses, requester i at [32*i +: 32]
//   req_din        : flattened write data, requester i at [WIDTH*i +: WIDTH]
//   gnt            : combinational ready, one-hot or zero
//   rvalid/rdata   : read response strobe per requester, shared read data
//   oob_err        : sticky flag, set by any access at/above ram_length
//   ram_*          : registered command to the RAM, ram_dout/ram_length back
//
// Handshake: requester i is accepted at a rising edge where req[i] and gnt[i]
// are both 1. Until then it holds req and payload steady; dropping req before
// acceptance withdraws the request. gnt never depends on req_we/req_address.
module dualportram_port_arbiter
  import dualportram_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*32-1:0]    req_address,
  input  logic [NREQ*WIDTH-1:0] req_din,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  oob_err,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [31:0]           ram_address,
  output logic [WIDTH-1:0]      ram_din,
  input  logic [WIDTH-1:0]      ram_dout,
  input  logic [31:0]           ram_length
);

  logic [NREQ-1:0]  w_gnt;
  logic             w_accept;
  logic             w_sel_we;
  logic [31:0]      w_sel_addr;
  logic [WIDTH-1:0] w_sel_din;
  logic             w_in_range;

  logic             r_ram_we;
  logic             r_ram_oe;
  logic [31:0]      r_ram_address;
  logic [WIDTH-1:0] r_ram_din;
  logic             r_oob_err;
  // Read response pipeline: one-hot owner (zero = empty slot) and OOB bit.
  logic [NREQ-1:0]  r_pipe_owner [READ_LATENCY];
  logic             r_pipe_oob   [READ_LATENCY];

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .i_req     (req),
    .i_advance (w_accept),
    .o_gnt     (w_gnt)
  );

  assign gnt      = w_gnt;
  assign w_accept = |(req & w_gnt);

  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_we   = req_we[i];
        w_sel_addr = req_address[32*i +: 32];
        w_sel_din  = req_din[WIDTH*i +: WIDTH];
      end
    end
  end

  assign w_in_range = (w_sel_addr < ram_length);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_we      <= 1'b0;
      r_ram_oe      <= 1'b0;
      r_ram_address <= '0;
      r_ram_din     <= '0;
      r_oob_err     <= 1'b0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_pipe_owner[s] <= '0;
        r_pipe_oob[s]   <= 1'b0;
      end
    end else begin
      // Out-of-range accesses are accepted but never reach the RAM.
      r_ram_we <= w_accept & w_sel_we & w_in_range;
      r_ram_oe <= w_accept & ~w_sel_we & w_in_range;
      if (w_accept) begin
        r_ram_address <= w_sel_addr;
        r_ram_din     <= w_sel_din;
      end
      if (w_accept && !w_in_range) r_oob_err <= 1'b1;
      // Out-of-range reads still get a response so the requester is not left waiting.
      r_pipe_owner[0] <= (w_accept && !w_sel_we) ? w_gnt : '0;
      r_pipe_oob[0]   <= ~w_in_range;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_pipe_owner[s] <= r_pipe_owner[s-1];
        r_pipe_oob[s]   <= r_pipe_oob[s-1];
      end
    end
  end

  assign ram_we      = r_ram_we;
  assign ram_oe      = r_ram_oe;
  assign ram_address = r_ram_address;
  assign ram_din     = r_ram_din;
  assign oob_err     = r_oob_err;
  assign rvalid      = r_pipe_owner[READ_LATENCY-1];
  // ram_dout is registered inside the RAM, so it lines up with the last stage.
  assign rdata       = r_pipe_oob[READ_LATENCY-1] ? '0 : ram_dout;

endmodule

// File: tb/tb_dualportram_port_arbiter.sv
module tb_dualportram_port_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*32-1:0]    req_address;
  logic [NREQ*WIDTH-1:0] req_din;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rvalid;
  logic [WIDTH-1:0]      rdata;
  logic                  oob_err;
  logic                  ram_we;
  logic                  ram_oe;
  logic [31:0]           ram_address;
  logic [WIDTH-1:0]      ram_din;
  logic [WIDTH-1:0]      ram_dout;
  logic [31:0]           ram_length;

  dualportram_port_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_we      (req_we),
    .req_address (req_address),
    .req_din     (req_din),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .oob_err     (oob_err),
    .ram_we      (ram_we),
    .ram_oe      (ram_oe),
    .ram_address (ram_address),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout),
    .ram_length  (ram_length)
  );

  // ---------------- RAM stand-in (registered read) ----------------
  logic [31:0] ram_mem [0:2047];

  function automatic logic [31:0] pre(input int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h00010001);
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) ram_mem[i] <= pre(i);
    ram_mem[5] <= 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_address[10:0]] <= ram_din;
    if (ram_oe) ram_dout <= ram_mem[ram_address[10:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req = '0; req_we = '0; req_address = '0; req_din = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_address[32*i +: 32] = a;
    req_din[WIDTH*i +: WIDTH] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_req();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- reference model (random phase) ----------------
  logic            m_pend [NREQ];
  logic            m_we   [NREQ];
  logic [31:0]     m_addr [NREQ];
  logic [31:0]     m_din  [NREQ];
  int              m_ptr;
  logic            m_oob;
  logic [31:0]     m_mem [0:2047];
  logic            e_we, e_oe;
  logic [31:0]     e_addr, e_din;
  logic [WIDTH-1:0] exp_q[$];
  logic [NREQ-1:0]  exp_owner_q[$];
  int               exp_due_q[$];
  int               cyc;

  // Winner = first requesting index met when counting up from the pointer.
  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] r, input int p);
    logic [NREQ-1:0] g;
    bit found;
    g = '0;
    found = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && r[(p + j) % NREQ]) begin
        g[(p + j) % NREQ] = 1'b1;
        found = 1;
      end
    end
    return g;
  endfunction

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 32'd1024;
    if (r == 1) return 32'd1023;
    if (r == 2) return 32'd1024 + 32'($urandom_range(1, 5));
    return 32'd512 + 32'($urandom_range(0, 15));
  endfunction

  task automatic rnd_cycle(input bit allow_new);
    logic [NREQ-1:0] pv;
    logic [NREQ-1:0] g;
    int k;
    logic inr;
    pv = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!allow_new) m_pend[i] = 1'b0;
      else if (m_pend[i]) begin
        if ($urandom_range(0, 7) == 0) m_pend[i] = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        m_pend[i] = 1'b1;
        m_we[i]   = 1'($urandom_range(0, 1));
        m_addr[i] = rnd_addr();
        m_din[i]  = $urandom();
      end
    end
    clear_req();
    for (int i = 0; i < NREQ; i++) begin
      if (m_pend[i]) begin
        set_req(i, m_we[i], m_addr[i], m_din[i]);
        pv[i] = 1'b1;
      end
    end
    @(negedge clk);
    g = model_grant(pv, m_ptr);
    check("rnd_gnt", 64'(gnt), 64'(g));
    check("rnd_ram_we", 64'(ram_we), 64'(e_we));
    check("rnd_ram_oe", 64'(ram_oe), 64'(e_oe));
    if (e_we || e_oe) check("rnd_ram_address", 64'(ram_address), 64'(e_addr));
    if (e_we) check("rnd_ram_din", 64'(ram_din), 64'(e_din));
    check("rnd_oob_err", 64'(oob_err), 64'(m_oob));
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      check("rnd_rvalid", 64'(rvalid), 64'(exp_owner_q[0]));
      check("rnd_rdata", 64'(rdata), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      void'(exp_owner_q.pop_front());
      void'(exp_due_q.pop_front());
    end else begin
      check("rnd_rvalid_idle", 64'(rvalid), 64'h0);
    end
    // Effects of the coming edge.
    e_we = 1'b0;
    e_oe = 1'b0;
    k = -1;
    for (int i = 0; i < NREQ; i++) if (g[i]) k = i;
    if (k >= 0) begin
      m_ptr = (k + 1) % NREQ;
      m_pend[k] = 1'b0;
      inr = (m_addr[k] < ram_length);
      if (!inr) m_oob = 1'b1;
      if (m_we[k]) begin
        if (inr) begin
          e_we = 1'b1; e_addr = m_addr[k]; e_din = m_din[k];
          m_mem[m_addr[k][10:0]] = m_din[k];
        end
      end else begin
        if (inr) begin
          e_oe = 1'b1; e_addr = m_addr[k];
        end
        exp_q.push_back(inr ? m_mem[m_addr[k][10:0]] : 32'h0);
        exp_owner_q.push_back(g);
        exp_due_q.push_back(cyc + 2);
      end
    end
    cyc++;
    tick();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] exp_gnt;
  } vec_t;
  vec_t vecs[12];

  // ---------------- main test ----------------
  initial begin
    logic prev_we;

    vecs[0]  = '{4'b0000, 4'b0000};
    vecs[1]  = '{4'b0100, 4'b0100};
    vecs[2]  = '{4'b0011, 4'b0001};
    vecs[3]  = '{4'b1001, 4'b1000};
    vecs[4]  = '{4'b1001, 4'b0001};
    vecs[5]  = '{4'b1111, 4'b0010};
    vecs[6]  = '{4'b1111, 4'b0100};
    vecs[7]  = '{4'b1111, 4'b1000};
    vecs[8]  = '{4'b1111, 4'b0001};
    vecs[9]  = '{4'b0001, 4'b0001};
    vecs[10] = '{4'b0000, 4'b0000};
    vecs[11] = '{4'b0110, 4'b0010};

    ram_length = 32'd1024;
    clear_req();
    do_reset();

    // Reset values.
    @(negedge clk);
    check("rst_ram_we", 64'(ram_we), 64'h0);
    check("rst_ram_oe", 64'(ram_oe), 64'h0);
    check("rst_ram_address", 64'(ram_address), 64'h0);
    check("rst_ram_din", 64'(ram_din), 64'h0);
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_oob_err", 64'(oob_err), 64'h0);
    check("rst_gnt", 64'(gnt), 64'h0);
    tick();

    // Arbitration table: all in-range writes, grant order and write strobes.
    prev_we = 1'b0;
    for (int v = 0; v < 12; v++) begin
      clear_req();
      for (int i = 0; i < NREQ; i++)
        if (vecs[v].req[i]) set_req(i, 1'b1, 32'(100 + i), 32'hA0000000 + 32'(i));
      @(negedge clk);
      check($sformatf("tbl_gnt[%0d]", v), 64'(gnt), 64'(vecs[v].exp_gnt));
      check($sformatf("tbl_we[%0d]", v), 64'(ram_we), 64'(prev_we));
      prev_we = |vecs[v].exp_gnt;
      tick();
    end
    clear_req();
    @(negedge clk);
    check("tbl_we_last", 64'(ram_we), 64'(prev_we));
    check("tbl_addr_last", 64'(ram_address), 64'd101);
    check("tbl_din_last", 64'(ram_din), 64'hA0000001);
    tick();

    // Single read by requester 2.
    set_req(2, 1'b0, 32'd5, 32'h0);
    @(negedge clk);
    check("rd_gnt", 64'(gnt), 64'h4);
    tick();
    clear_req();
    @(negedge clk);
    check("rd_ram_oe", 64'(ram_oe), 64'h1);
    check("rd_ram_we", 64'(ram_we), 64'h0);
    check("rd_ram_address", 64'(ram_address), 64'd5);
    check("rd_rvalid_early", 64'(rvalid), 64'h0);
    tick();
    @(negedge clk);
    check("rd_rvalid", 64'(rvalid), 64'h4);
    check("rd_rdata", 64'(rdata), 64'hDEADBEEF);
    tick();
    @(negedge clk);
    check("rd_rvalid_pulse", 64'(rvalid), 64'h0);
    tick();

    // Out-of-range read at ram_length, then legal read at ram_length-1.
    set_req(1, 1'b0, 32'd1024, 32'h0);
    @(negedge clk);
    check("oob_gnt", 64'(gnt), 64'h2);
    tick();
    clear_req();
    @(negedge clk);
    check("oob_ram_oe", 64'(ram_oe), 64'h0);
    check("oob_ram_we", 64'(ram_we), 64'h0);
    check("oob_err_set", 64'(oob_err), 64'h1);
    tick();
    @(negedge clk);
    check("oob_rvalid", 64'(rvalid), 64'h2);
    check("oob_rdata", 64'(rdata), 64'h0);
    tick();
    set_req(1, 1'b0, 32'd1023, 32'h0);
    @(negedge clk);
    check("edge_gnt", 64'(gnt), 64'h2);
    tick();
    clear_req();
    @(negedge clk);
    check("edge_ram_oe", 64'(ram_oe), 64'h1);
    check("edge_ram_address", 64'(ram_address), 64'd1023);
    tick();
    @(negedge clk);
    check("edge_rvalid", 64'(rvalid), 64'h2);
    check("edge_rdata", 64'(rdata), 64'(pre(1023)));
    check("oob_err_held", 64'(oob_err), 64'h1);
    tick();

    // Write then read of the same address on consecutive accepts.
    do_reset();
    set_req(0, 1'b1, 32'd7, 32'h12345678);
    @(negedge clk);
    check("wr_gnt", 64'(gnt), 64'h1);
    tick();
    clear_req();
    set_req(0, 1'b0, 32'd7, 32'h0);
    @(negedge clk);
    check("wr_ram_we", 64'(ram_we), 64'h1);
    check("wr_ram_address", 64'(ram_address), 64'd7);
    check("wr_ram_din", 64'(ram_din), 64'h12345678);
    check("wrrd_gnt", 64'(gnt), 64'h1);
    tick();
    clear_req();
    @(negedge clk);
    check("wrrd_ram_oe", 64'(ram_oe), 64'h1);
    check("wrrd_ram_we", 64'(ram_we), 64'h0);
    tick();
    @(negedge clk);
    check("wrrd_rvalid", 64'(rvalid), 64'h1);
    check("wrrd_rdata", 64'(rdata), 64'h12345678);
    tick();

    // Reset with two reads in flight.
    set_req(0, 1'b0, 32'd5, 32'h0);
    set_req(1, 1'b0, 32'd5, 32'h0);
    @(negedge clk);
    check("mid_gnt0", 64'(gnt), 64'h2);
    tick();
    clear_req();
    set_req(0, 1'b0, 32'd5, 32'h0);
    @(negedge clk);
    check("mid_gnt1", 64'(gnt), 64'h1);
    tick();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'd6, 32'h0);
    @(negedge clk);
    check("mid_gnt_in_reset", 64'(gnt), 64'h0);
    tick();
    reset = 1'b0;
    clear_req();
    @(negedge clk);
    check("mid_rvalid", 64'(rvalid), 64'h0);
    check("mid_ram_oe", 64'(ram_oe), 64'h0);
    check("mid_ram_we", 64'(ram_we), 64'h0);
    check("mid_ram_address", 64'(ram_address), 64'h0);
    check("mid_ram_din", 64'(ram_din), 64'h0);
    check("mid_oob_err", 64'(oob_err), 64'h0);
    tick();
    @(negedge clk);
    check("mid_rvalid_late", 64'(rvalid), 64'h0);
    tick();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'd6, 32'h0);
    @(negedge clk);
    check("mid_first_winner", 64'(gnt), 64'h1);
    tick();
    clear_req();

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 2048; i++) m_mem[i] = pre(i);
    for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
    m_ptr = 0; m_oob = 1'b0; e_we = 1'b0; e_oe = 1'b0;
    e_addr = '0; e_din = '0; cyc = 0;
    for (int n = 0; n < 300; n++) rnd_cycle(1'b1);
    for (int n = 0; n < 4; n++) rnd_cycle(1'b0);
    check("rnd_drain", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
